// File: rtl/serial_n_bit_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and counter sizing.
package serial_n_bit_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter width: ceil(log2(n)), never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_n_bit_adder_if.sv
// Start/busy/done handshake and operand/result bus for the bit-serial adder.
interface serial_n_bit_adder_if #(parameter int N = 4);
  logic         start;
  logic         enable;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic [N-1:0] S;
  logic         cout;
  logic         busy;
  logic         done;

  modport master (output start, enable, a, b, cin,
                  input  S, cout, busy, done);
  modport slave  (input  start, enable, a, b, cin,
                  output S, cout, busy, done);
endinterface

// File: rtl/serial_n_bit_adder_full_adder.sv
// Single-bit full adder; the addition twin of full_subtractor.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_n_bit_adder.sv
// Bit-serial N-bit adder: one full_adder cell, registered carry, LSB first.
// state | meaning
// IDLE  | waiting for start
// RUN   | one result bit per enabled edge, busy high
// DONE  | one-cycle done pulse, S/cout just updated; start accepted again
module serial_n_bit_adder
  import serial_n_bit_adder_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                clk,
  input  logic                rst,
  serial_n_bit_adder_if.slave bus
);
  localparam int CW = cnt_width(N);

  state_t        state, state_nxt;
  logic [N-1:0]  a_sh, b_sh, r_sh, r_nxt;
  logic          carry, s_bit, c_bit;
  logic [CW-1:0] cnt;
  logic          accept, step, last;

  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (s_bit),
    .cout (c_bit)
  );

  // New bit enters at the MSB so the LSB-first stream lands in place after N steps.
  generate
    if (N == 1) begin : g_r1
      assign r_nxt = s_bit;
    end else begin : g_rn
      assign r_nxt = {s_bit, r_sh[N-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    accept    = bus.start && (state != RUN);
    step      = (state == RUN) && bus.enable;
    last      = step && (cnt == CW'(N - 1));
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last)   state_nxt = DONE;
      DONE:    state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      r_sh     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      bus.S    <= '0;
      bus.cout <= 1'b0;
    end else if (accept) begin
      a_sh  <= bus.a;
      b_sh  <= bus.b;
      r_sh  <= '0;
      carry <= bus.cin;
      cnt   <= '0;
    end else if (step) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      r_sh  <= r_nxt;
      carry <= c_bit;
      // Hold the counter on the final bit so it never wraps.
      if (!last) cnt <= cnt + 1'b1;
      if (last) begin
        bus.S    <= r_nxt;
        bus.cout <= c_bit;
      end
    end
  end

endmodule

// File: tb/tb_serial_n_bit_adder.sv
// Directed bench for serial_n_bit_adder (N=4) with immediate-assertion checks.
module tb_serial_n_bit_adder;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests  = 0;
  int   failed = 0;

  serial_n_bit_adder_if #(.N(N)) bus ();
  serial_n_bit_adder #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_add(input int av, input int bv, input int cv);
    bus.a     = 4'(av);
    bus.b     = 4'(bv);
    bus.cin   = 1'(cv);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Ticks until done is seen; returns edges taken and busy cycles observed.
  task automatic wait_done(output int cyc, output int busy_cnt);
    cyc = 0;
    busy_cnt = 0;
    while (bus.done !== 1'b1 && cyc < 100) begin
      if (bus.busy === 1'b1) busy_cnt++;
      tick();
      cyc++;
    end
    check("done_seen", 32'(bus.done), 32'd1);
  endtask

  int          cyc, bcnt;
  logic [N-1:0] s_hold;
  logic        saw_done;

  initial begin
    bus.start = 1'b0; bus.enable = 1'b1;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    #2;
    check("rst_S",    32'(bus.S),    32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    #10 rst = 1'b0;
    tick();

    // 5 + 6
    start_add(5, 6, 0);
    check("busy_after_start", 32'(bus.busy), 32'd1);
    wait_done(cyc, bcnt);
    check("lat_5p6", 32'(cyc), 32'd4);
    check("busy_cycles_5p6", 32'(bcnt), 32'd4);
    check("S_5p6", 32'(bus.S), 32'd11);
    check("cout_5p6", 32'(bus.cout), 32'd0);
    check("busy_in_done", 32'(bus.busy), 32'd0);
    tick();
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("S_hold_idle", 32'(bus.S), 32'd11);

    // 9 + 8 and 15 + 15 + 1
    start_add(9, 8, 0);
    wait_done(cyc, bcnt);
    check("S_9p8", 32'(bus.S), 32'd1);
    check("cout_9p8", 32'(bus.cout), 32'd1);
    tick();
    start_add(15, 15, 1);
    wait_done(cyc, bcnt);
    check("S_15p15p1", 32'(bus.S), 32'd15);
    check("cout_15p15p1", 32'(bus.cout), 32'd1);
    tick();

    // 3 + 4 + 1 with a three-cycle stall after the first bit
    start_add(3, 4, 1);
    tick();
    bus.enable = 1'b0;
    s_hold = bus.S;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_S_hold", 32'(bus.S), 32'(s_hold));
      check("stall_busy", 32'(bus.busy), 32'd1);
      check("stall_no_done", 32'(bus.done), 32'd0);
    end
    bus.enable = 1'b1;
    wait_done(cyc, bcnt);
    check("lat_stall_total", 32'(cyc + 4), 32'd7);
    check("S_3p4p1", 32'(bus.S), 32'd8);
    check("cout_3p4p1", 32'(bus.cout), 32'd0);
    tick();

    // start during RUN ignored, then held through DONE for a back-to-back add
    start_add(2, 2, 0);
    bus.a = 4'd1; bus.b = 4'd1; bus.cin = 1'b0; bus.start = 1'b1;
    wait_done(cyc, bcnt);
    check("lat_ignored_start", 32'(cyc), 32'd4);
    check("S_2p2", 32'(bus.S), 32'd4);
    tick();
    bus.start = 1'b0;
    check("b2b_busy", 32'(bus.busy), 32'd1);
    wait_done(cyc, bcnt);
    check("lat_b2b", 32'(cyc), 32'd4);
    check("S_1p1", 32'(bus.S), 32'd2);
    tick();

    // asynchronous reset in the middle of RUN
    start_add(6, 5, 0);
    tick();
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_S", 32'(bus.S), 32'd0);
    check("arst_cout", 32'(bus.cout), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    #1 rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    check("arst_no_done", 32'(saw_done), 32'd0);
    check("arst_S_hold", 32'(bus.S), 32'd0);
    start_add(7, 1, 0);
    wait_done(cyc, bcnt);
    check("S_7p1", 32'(bus.S), 32'd8);
    check("cout_7p1", 32'(bus.cout), 32'd0);
    tick();

    // exhaustive sweep
    for (int av = 0; av < 16; av++)
      for (int bv = 0; bv < 16; bv++)
        for (int cv = 0; cv < 2; cv++) begin
          start_add(av, bv, cv);
          wait_done(cyc, bcnt);
          check($sformatf("sweep_%0d_%0d_%0d", av, bv, cv),
                32'({bus.cout, bus.S}), 32'(av + bv + cv));
        end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
